vanilla_scoreboard_latency_tracker: RTL and testbench
=====================================================

Name: vanilla_scoreboard_latency_tracker

Overview:
- Testbench-side successor to the per-core scoreboard tracker, generalised to num_rf_p register files (int, float, ...), parametrised register count and num_cat_p outstanding-op categories.
- Per register, records which category set the scoreboard bit and when. On clear, it measures set-to-clear latency and accumulates per-RF, per-category statistics.
- Sits beside each vanilla core in the testbench. Driven by decoded set events from ID and clear events from the writeback/response path.

Parameters:
- num_rf_p, 2, number of register files tracked (0 = int, 1 = float).
- reg_els_p, 32, registers per file.
- num_cat_p, 8, categories (idiv, fdiv_fsqrt, dram_load, dram_amo, global_load, group_load, group_amo, dmem_overflow).
- lat_width_p, 16, per-entry latency timer width; saturating.
- cnt_width_p, 32, statistics counter width; saturating.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous reset, active low.
- set_v_i  in  num_rf_p  set event per RF; caller already qualifies it with ~stall_id & ~stall_all & ~flush.
- set_id_i  in  num_rf_p*log2(reg_els_p)  register being set.
- set_cat_i  in  num_rf_p*log2(num_cat_p)  category of the set.
- clear_v_i  in  num_rf_p  clear event per RF.
- clear_id_i  in  num_rf_p*log2(reg_els_p)  register being cleared.
- pending_o  out  num_rf_p*reg_els_p  outstanding bit per register.
- pending_cat_o  out  num_rf_p*reg_els_p*log2(num_cat_p)  category of each outstanding entry.
- done_cnt_o  out  num_rf_p*num_cat_p*cnt_width_p  completed ops per RF/category.
- lat_sum_o  out  num_rf_p*num_cat_p*cnt_width_p  summed latencies.
- lat_max_o  out  num_rf_p*num_cat_p*lat_width_p  maximum latency observed.
- err_double_set_o  out  num_rf_p  sticky flag: set hit an already-pending register.
- err_orphan_clear_o  out  num_rf_p  sticky flag: clear hit a non-pending register.

Behaviour:
- Reset (reset_n_i == 0 at a posedge): all outputs, entries and timers go to 0. Reset wins over any event in the same cycle.
- Entry state per register is two-state, IDLE and PEND, held in the pending bit.
  - IDLE -> PEND on set: store category, load timer with 1.
  - PEND -> IDLE on clear.
- Timer: each PEND entry increments its timer every cycle, saturating at 2^lat_width_p - 1.
- Latency: the value reported on clear is the timer value in the clearing cycle.
  - Set at posedge N, clear sampled at posedge N+k gives latency k.
  - Minimum latency is 1.
- Clear of a PEND entry (retires at the same posedge):
  - done_cnt[rf][cat] += 1.
  - lat_sum += latency.
  - lat_max = max(lat_max, latency).
  - All three update exactly one cycle after the clear is sampled. Counters saturate; they never wrap.
- Set and clear on the same register, same RF, same cycle: the old entry retires with its latency and category, then the new entry is installed (timer = 1, new category). No error is flagged.
- Set and clear on different registers in the same cycle: both take effect independently.
- Set on a PEND register with no matching clear: err_double_set_o goes sticky, the entry is overwritten and the timer restarts. The old op is not counted.
- Clear on an IDLE register: err_orphan_clear_o goes sticky. No stats change.
- The RFs are fully independent. Events in different RFs in the same cycle do not interact.
- Register 0 of RF 0 is treated like any other register; the caller filters x0.

Optional Feature:
- Macro VANILLA_SB_TRACKER_HIST_EN.
- When defined:
  - Adds output lat_hist_o, num_rf_p*num_cat_p*lat_width_p*cnt_width_p bits.
  - Bucket b counts retirements with floor(log2(latency)) == b; latencies saturated at the timer max fall in bucket lat_width_p-1.
  - Buckets saturate and reset to 0; they update in the same cycle as done_cnt.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vanilla_scoreboard_tracker_pkg:
  - enum vanilla_sb_cat_e (category codes in the order listed under num_cat_p).
  - struct vanilla_sb_entry_s {pending, cat, timer}.
  - struct vanilla_sb_stat_s {done_cnt, lat_sum, lat_max}.
- Sub-module vanilla_sb_rf_tracker: one register file's entry array and statistics. The top instantiates num_rf_p copies and flattens their outputs.

Test Plan:
- Set RF0 r5 cat dram_load at cycle 10, clear at cycle 47 -> done_cnt[0][dram_load] = 1, lat_sum = 37, lat_max = 37 at cycle 48; pending_o bit 5 = 0.
- Set RF1 r3 fdiv, then same-cycle clear r3 plus set r3 idiv after 20 cycles -> one fdiv retirement with latency 20; r3 stays pending with cat idiv and timer 1; no error flags.
- Set r7 twice without a clear -> err_double_set_o[0] = 1 sticky; on the later clear only one retirement is counted, with latency measured from the second set.
- Clear r9 while it is idle -> err_orphan_clear_o = 1; all counters unchanged.
- lat_width_p = 4: hold r2 pending for 40 cycles -> lat_max = 15, lat_sum += 15; with HIST_EN, bucket 3 increments.
- Drive reset_n_i low for one cycle while 10 entries are pending, then apply clears -> all outputs 0 after reset; the later clears raise only err_orphan_clear_o.

Source files
------------

// File: rtl/vanilla_scoreboard_latency_tracker_pkg.sv
// Shared types for the scoreboard latency tracker: category codes, per-register entry and per-category statistics.
// Containers are sized for the widest supported build (lat_width_p <= 32, cnt_width_p <= 64, num_cat_p <= 8).
package vanilla_scoreboard_tracker_pkg;

    localparam int unsigned sb_cat_w   = 3;
    localparam int unsigned sb_timer_w = 32;
    localparam int unsigned sb_cnt_w   = 64;

    typedef enum logic [sb_cat_w-1:0] {
        SB_CAT_IDIV          = 3'd0,
        SB_CAT_FDIV_FSQRT    = 3'd1,
        SB_CAT_DRAM_LOAD     = 3'd2,
        SB_CAT_DRAM_AMO      = 3'd3,
        SB_CAT_GLOBAL_LOAD   = 3'd4,
        SB_CAT_GROUP_LOAD    = 3'd5,
        SB_CAT_GROUP_AMO     = 3'd6,
        SB_CAT_DMEM_OVERFLOW = 3'd7
    } vanilla_sb_cat_e;

    typedef struct packed {
        logic                  pending;
        vanilla_sb_cat_e       cat;
        logic [sb_timer_w-1:0] timer;
    } vanilla_sb_entry_s;

    typedef struct packed {
        logic [sb_cnt_w-1:0]   done_cnt;
        logic [sb_cnt_w-1:0]   lat_sum;
        logic [sb_timer_w-1:0] lat_max;
    } vanilla_sb_stat_s;

    // Index of the highest set bit; callers never pass zero since the minimum latency is 1.
    function automatic int floor_log2(input logic [sb_timer_w-1:0] v);
        floor_log2 = 0;
        for (int i = 0; i < sb_timer_w; i++) begin
            if (v[i]) floor_log2 = i;
        end
    endfunction

endpackage

// File: rtl/vanilla_scoreboard_latency_tracker_if.sv
// Set/clear event bundle from the core's ID and writeback paths into the latency tracker.
interface vanilla_scoreboard_latency_tracker_if #(
    parameter int unsigned num_rf_p  = 2,
    parameter int unsigned reg_els_p = 32,
    parameter int unsigned num_cat_p = 8
);
    localparam int unsigned id_w  = $clog2(reg_els_p);
    localparam int unsigned cat_w = $clog2(num_cat_p);

    logic [num_rf_p-1:0]       set_v;
    logic [num_rf_p*id_w-1:0]  set_id;
    logic [num_rf_p*cat_w-1:0] set_cat;
    logic [num_rf_p-1:0]       clear_v;
    logic [num_rf_p*id_w-1:0]  clear_id;

    modport master (output set_v, set_id, set_cat, clear_v, clear_id);
    modport slave  (input  set_v, set_id, set_cat, clear_v, clear_id);
endinterface

// File: rtl/vanilla_scoreboard_latency_tracker_rf_tracker.sv
// One register file's pending entries, set-to-clear timers and per-category retirement statistics.
// Optional latency histogram under VANILLA_SB_TRACKER_HIST_EN.
module vanilla_sb_rf_tracker
    import vanilla_scoreboard_tracker_pkg::*;
#(
    parameter  int unsigned reg_els_p   = 32,
    parameter  int unsigned num_cat_p   = 8,
    parameter  int unsigned lat_width_p = 16,
    parameter  int unsigned cnt_width_p = 32,
    localparam int unsigned id_w        = $clog2(reg_els_p),
    localparam int unsigned cat_w       = $clog2(num_cat_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               set_v_i,
    input  logic [id_w-1:0]                    set_id_i,
    input  logic [cat_w-1:0]                   set_cat_i,
    input  logic                               clear_v_i,
    input  logic [id_w-1:0]                    clear_id_i,
    output logic [reg_els_p-1:0]               pending_o,
    output logic [reg_els_p*cat_w-1:0]         pending_cat_o,
    output logic [num_cat_p*cnt_width_p-1:0]   done_cnt_o,
    output logic [num_cat_p*cnt_width_p-1:0]   lat_sum_o,
    output logic [num_cat_p*lat_width_p-1:0]   lat_max_o,
    output logic                               err_double_set_o,
    output logic                               err_orphan_clear_o
`ifdef VANILLA_SB_TRACKER_HIST_EN
    ,
    output logic [num_cat_p*lat_width_p*cnt_width_p-1:0] lat_hist_o
`endif
);

    localparam logic [sb_timer_w-1:0] timer_max_c = {sb_timer_w{1'b1}} >> (sb_timer_w - lat_width_p);
    localparam logic [sb_cnt_w-1:0]   cnt_max_c   = {sb_cnt_w{1'b1}} >> (sb_cnt_w - cnt_width_p);

    vanilla_sb_entry_s entry_q [reg_els_p];
    vanilla_sb_entry_s entry_d [reg_els_p];
    vanilla_sb_stat_s  stat_q  [num_cat_p];
    vanilla_sb_stat_s  stat_d  [num_cat_p];
    logic              err_dbl_q, err_dbl_d;
    logic              err_orph_q, err_orph_d;

    logic                  retire;
    vanilla_sb_cat_e       ret_cat;
    logic [cat_w-1:0]      ret_idx;
    logic [sb_timer_w-1:0] ret_lat;
    logic [sb_cnt_w:0]     sum_ext;

    always_comb begin
        // NOTE: every signal written here is given its default first; a path that skipped an assignment would infer a latch.
        entry_d    = entry_q;
        stat_d     = stat_q;
        err_dbl_d  = err_dbl_q;
        err_orph_d = err_orph_q;

        // The retiring op's latency is its timer as seen in the clearing cycle.
        retire  = clear_v_i && entry_q[clear_id_i].pending;
        ret_cat = entry_q[clear_id_i].cat;
        ret_idx = cat_w'(ret_cat);
        ret_lat = entry_q[clear_id_i].timer;
        sum_ext = {1'b0, stat_q[ret_idx].lat_sum} + (sb_cnt_w + 1)'(ret_lat);

        for (int r = 0; r < reg_els_p; r++) begin
            if (entry_q[r].pending && entry_q[r].timer != timer_max_c) begin
                entry_d[r].timer = entry_q[r].timer + 1'b1;
            end
        end

        if (clear_v_i) begin
            if (retire) entry_d[clear_id_i].pending = 1'b0;
            else        err_orph_d = 1'b1;
        end

        // Set is applied after clear so a same-register set/clear retires the old op and installs the new one.
        if (set_v_i) begin
            if (entry_q[set_id_i].pending && !(clear_v_i && clear_id_i == set_id_i)) err_dbl_d = 1'b1;
            entry_d[set_id_i].pending = 1'b1;
            entry_d[set_id_i].cat     = vanilla_sb_cat_e'(sb_cat_w'(set_cat_i));
            entry_d[set_id_i].timer   = sb_timer_w'(1);
        end

        if (retire) begin
            if (stat_q[ret_idx].done_cnt != cnt_max_c) begin
                stat_d[ret_idx].done_cnt = stat_q[ret_idx].done_cnt + 1'b1;
            end
            stat_d[ret_idx].lat_sum = (sum_ext > {1'b0, cnt_max_c}) ? cnt_max_c : sum_ext[sb_cnt_w-1:0];
            if (ret_lat > stat_q[ret_idx].lat_max) stat_d[ret_idx].lat_max = ret_lat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            // NOTE: the entry and statistic arrays are discrete flops, not RAM, so clearing every element in reset is legal.
            for (int r = 0; r < reg_els_p; r++) entry_q[r] <= '0;
            for (int c = 0; c < num_cat_p; c++) stat_q[c] <= '0;
            err_dbl_q  <= 1'b0;
            err_orph_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop captures the pre-edge value of its _d.
            entry_q    <= entry_d;
            stat_q     <= stat_d;
            err_dbl_q  <= err_dbl_d;
            err_orph_q <= err_orph_d;
        end
    end

    for (genvar r = 0; r < reg_els_p; r++) begin : g_entry_out
        assign pending_o[r]                   = entry_q[r].pending;
        assign pending_cat_o[r*cat_w +: cat_w] = cat_w'(entry_q[r].cat);
    end

    for (genvar c = 0; c < num_cat_p; c++) begin : g_stat_out
        assign done_cnt_o[c*cnt_width_p +: cnt_width_p] = stat_q[c].done_cnt[cnt_width_p-1:0];
        assign lat_sum_o[c*cnt_width_p +: cnt_width_p]  = stat_q[c].lat_sum[cnt_width_p-1:0];
        assign lat_max_o[c*lat_width_p +: lat_width_p]  = stat_q[c].lat_max[lat_width_p-1:0];
    end

    assign err_double_set_o   = err_dbl_q;
    assign err_orphan_clear_o = err_orph_q;

`ifdef VANILLA_SB_TRACKER_HIST_EN
    logic [sb_cnt_w-1:0] hist_q [num_cat_p][lat_width_p];
    logic [sb_cnt_w-1:0] hist_d [num_cat_p][lat_width_p];
    int                  bucket;

    // Saturated latencies equal 2^lat_width_p-1 and so land in the top bucket without special casing.
    always_comb begin
        hist_d = hist_q;
        bucket = floor_log2(ret_lat);
        if (retire) begin
            for (int b = 0; b < lat_width_p; b++) begin
                if (b == bucket && hist_q[ret_idx][b] != cnt_max_c) begin
                    hist_d[ret_idx][b] = hist_q[ret_idx][b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < num_cat_p; c++) begin
                for (int b = 0; b < lat_width_p; b++) hist_q[c][b] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    for (genvar c = 0; c < num_cat_p; c++) begin : g_hist_cat
        for (genvar b = 0; b < lat_width_p; b++) begin : g_hist_bkt
            assign lat_hist_o[(c*lat_width_p + b)*cnt_width_p +: cnt_width_p] = hist_q[c][b][cnt_width_p-1:0];
        end
    end
`endif

endmodule

// File: rtl/vanilla_scoreboard_latency_tracker.sv
// Scoreboard latency tracker: one vanilla_sb_rf_tracker per register file, outputs flattened RF-major.
// Define VANILLA_SB_TRACKER_HIST_EN to add the per-RF/category log2 latency histogram output.
module vanilla_scoreboard_latency_tracker
    import vanilla_scoreboard_tracker_pkg::*;
#(
    parameter  int unsigned num_rf_p    = 2,
    parameter  int unsigned reg_els_p   = 32,
    parameter  int unsigned num_cat_p   = 8,
    parameter  int unsigned lat_width_p = 16,
    parameter  int unsigned cnt_width_p = 32,
    localparam int unsigned id_w        = $clog2(reg_els_p),
    localparam int unsigned cat_w       = $clog2(num_cat_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    vanilla_scoreboard_latency_tracker_if.slave       ev,
    output logic [num_rf_p*reg_els_p-1:0]             pending_o,
    output logic [num_rf_p*reg_els_p*cat_w-1:0]       pending_cat_o,
    output logic [num_rf_p*num_cat_p*cnt_width_p-1:0] done_cnt_o,
    output logic [num_rf_p*num_cat_p*cnt_width_p-1:0] lat_sum_o,
    output logic [num_rf_p*num_cat_p*lat_width_p-1:0] lat_max_o,
    output logic [num_rf_p-1:0]                       err_double_set_o,
    output logic [num_rf_p-1:0]                       err_orphan_clear_o
`ifdef VANILLA_SB_TRACKER_HIST_EN
    ,
    output logic [num_rf_p*num_cat_p*lat_width_p*cnt_width_p-1:0] lat_hist_o
`endif
);

    localparam int unsigned cnt_blk_w  = num_cat_p * cnt_width_p;
    localparam int unsigned max_blk_w  = num_cat_p * lat_width_p;
    localparam int unsigned hist_blk_w = num_cat_p * lat_width_p * cnt_width_p;

    // Register files are fully independent; each copy sees only its own slice of the event bundle.
    for (genvar g = 0; g < num_rf_p; g++) begin : g_rf
        vanilla_sb_rf_tracker #(
            .reg_els_p   (reg_els_p),
            .num_cat_p   (num_cat_p),
            .lat_width_p (lat_width_p),
            .cnt_width_p (cnt_width_p)
        ) u_rf (
            .clk_i              (clk_i),
            .reset_n_i          (reset_n_i),
            .set_v_i            (ev.set_v[g]),
            .set_id_i           (ev.set_id[g*id_w +: id_w]),
            .set_cat_i          (ev.set_cat[g*cat_w +: cat_w]),
            .clear_v_i          (ev.clear_v[g]),
            .clear_id_i         (ev.clear_id[g*id_w +: id_w]),
            .pending_o          (pending_o[g*reg_els_p +: reg_els_p]),
            .pending_cat_o      (pending_cat_o[g*reg_els_p*cat_w +: reg_els_p*cat_w]),
            .done_cnt_o         (done_cnt_o[g*cnt_blk_w +: cnt_blk_w]),
            .lat_sum_o          (lat_sum_o[g*cnt_blk_w +: cnt_blk_w]),
            .lat_max_o          (lat_max_o[g*max_blk_w +: max_blk_w]),
            .err_double_set_o   (err_double_set_o[g]),
            .err_orphan_clear_o (err_orphan_clear_o[g])
`ifdef VANILLA_SB_TRACKER_HIST_EN
            ,
            .lat_hist_o         (lat_hist_o[g*hist_blk_w +: hist_blk_w])
`endif
        );
    end

endmodule

// File: tb/tb_vanilla_scoreboard_latency_tracker.sv
// Directed bench for vanilla_scoreboard_latency_tracker: expected results are queued when stimulus is issued
// and a negedge monitor pops and compares them. A second instance with lat_width_p = 4 covers timer saturation.
module tb_vanilla_scoreboard_latency_tracker;

    localparam int NRF = 2, NREG = 32, NCAT = 8, LW = 16, CW = 32, SLW = 4, IDW = 5, CATW = 3;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    vanilla_scoreboard_latency_tracker_if #(.num_rf_p(NRF), .reg_els_p(NREG), .num_cat_p(NCAT)) m_if ();
    vanilla_scoreboard_latency_tracker_if #(.num_rf_p(NRF), .reg_els_p(NREG), .num_cat_p(NCAT)) s_if ();

    logic [NRF*NREG-1:0]      pending,     s_pending;
    logic [NRF*NREG*CATW-1:0] pending_cat, s_pending_cat;
    logic [NRF*NCAT*CW-1:0]   done_cnt,    s_done_cnt;
    logic [NRF*NCAT*CW-1:0]   lat_sum,     s_lat_sum;
    logic [NRF*NCAT*LW-1:0]   lat_max;
    logic [NRF*NCAT*SLW-1:0]  s_lat_max;
    logic [NRF-1:0]           err_dbl,  s_err_dbl;
    logic [NRF-1:0]           err_orph, s_err_orph;
`ifdef VANILLA_SB_TRACKER_HIST_EN
    logic [NRF*NCAT*LW*CW-1:0]  lat_hist;
    logic [NRF*NCAT*SLW*CW-1:0] s_lat_hist;
`endif

    vanilla_scoreboard_latency_tracker #(
        .num_rf_p(NRF), .reg_els_p(NREG), .num_cat_p(NCAT), .lat_width_p(LW), .cnt_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .ev(m_if),
        .pending_o(pending), .pending_cat_o(pending_cat), .done_cnt_o(done_cnt),
        .lat_sum_o(lat_sum), .lat_max_o(lat_max),
        .err_double_set_o(err_dbl), .err_orphan_clear_o(err_orph)
`ifdef VANILLA_SB_TRACKER_HIST_EN
        , .lat_hist_o(lat_hist)
`endif
    );

    vanilla_scoreboard_latency_tracker #(
        .num_rf_p(NRF), .reg_els_p(NREG), .num_cat_p(NCAT), .lat_width_p(SLW), .cnt_width_p(CW)
    ) dut_small (
        .clk_i(clk), .reset_n_i(reset_n), .ev(s_if),
        .pending_o(s_pending), .pending_cat_o(s_pending_cat), .done_cnt_o(s_done_cnt),
        .lat_sum_o(s_lat_sum), .lat_max_o(s_lat_max),
        .err_double_set_o(s_err_dbl), .err_orphan_clear_o(s_err_orph)
`ifdef VANILLA_SB_TRACKER_HIST_EN
        , .lat_hist_o(s_lat_hist)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {
        K_PEND, K_PCAT, K_DONE, K_SUM, K_MAX, K_EDBL, K_EORPH, K_PWORD, K_ANY, K_STAT,
        K_S_DONE, K_S_SUM, K_S_MAX, K_HIST, K_S_HIST
    } kind_e;

    typedef struct {
        int              due;
        kind_e           kind;
        int              rf;
        int              idx;
        longint unsigned val;
        string           name;
    } exp_t;

    exp_t q[$];

    function automatic longint unsigned get(input kind_e k, input int rf, input int idx);
        case (k)
            K_PEND:   return 64'(pending[rf*NREG + idx]);
            K_PCAT:   return 64'(pending_cat[(rf*NREG + idx)*CATW +: CATW]);
            K_DONE:   return 64'(done_cnt[(rf*NCAT + idx)*CW +: CW]);
            K_SUM:    return 64'(lat_sum[(rf*NCAT + idx)*CW +: CW]);
            K_MAX:    return 64'(lat_max[(rf*NCAT + idx)*LW +: LW]);
            K_EDBL:   return 64'(err_dbl[rf]);
            K_EORPH:  return 64'(err_orph[rf]);
            K_PWORD:  return 64'(pending[rf*NREG +: NREG]);
            K_ANY:    return 64'(|{pending, pending_cat, done_cnt, lat_sum, lat_max, err_dbl, err_orph,
                                   s_pending, s_pending_cat, s_done_cnt, s_lat_sum, s_lat_max, s_err_dbl, s_err_orph});
            K_STAT:   return 64'(|{done_cnt, lat_sum, lat_max});
            K_S_DONE: return 64'(s_done_cnt[(rf*NCAT + idx)*CW +: CW]);
            K_S_SUM:  return 64'(s_lat_sum[(rf*NCAT + idx)*CW +: CW]);
            K_S_MAX:  return 64'(s_lat_max[(rf*NCAT + idx)*SLW +: SLW]);
`ifdef VANILLA_SB_TRACKER_HIST_EN
            K_HIST:   return 64'(lat_hist[(rf*NCAT*LW + idx)*CW +: CW]);
            K_S_HIST: return 64'(s_lat_hist[(rf*NCAT*SLW + idx)*CW +: CW]);
`endif
            default:  return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    task automatic check(input longint unsigned act, input longint unsigned exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expectation for the state visible after the most recent step().
    task automatic expect_now(input kind_e k, input int rf, input int idx, input longint unsigned v, input string nm);
        exp_t e;
        e.due  = cyc;
        e.kind = k;
        e.rf   = rf;
        e.idx  = idx;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t            e;
        longint unsigned act;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            act = get(e.kind, e.rf, e.idx);
            if (e.due != cyc) begin
                errors++;
                $display("FAIL %s: checked late (due cycle %0d, checked cycle %0d)", e.name, e.due, cyc);
            end
            check(act, e.val, e.name);
        end
    end

    task automatic idle_inputs();
        m_if.set_v = '0; m_if.set_id = '0; m_if.set_cat = '0; m_if.clear_v = '0; m_if.clear_id = '0;
        s_if.set_v = '0; s_if.set_id = '0; s_if.set_cat = '0; s_if.clear_v = '0; s_if.clear_id = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_ev(input int rf, input int id, input int cat);
        m_if.set_v[rf]                = 1'b1;
        m_if.set_id[rf*IDW +: IDW]    = id[IDW-1:0];
        m_if.set_cat[rf*CATW +: CATW] = cat[CATW-1:0];
    endtask

    task automatic clr_ev(input int rf, input int id);
        m_if.clear_v[rf]              = 1'b1;
        m_if.clear_id[rf*IDW +: IDW]  = id[IDW-1:0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        expect_now(K_ANY, 0, 0, 0, "reset_all_zero");
        reset_n = 1'b1;
        step();

        // RF0 r5 dram_load, cleared 37 cycles later.
        set_ev(0, 5, 2);
        step();
        expect_now(K_PEND, 0, 5, 1, "t1_pending");
        expect_now(K_PCAT, 0, 5, 2, "t1_pending_cat");
        idle(36);
        expect_now(K_DONE, 0, 2, 0, "t1_done_before_clear");
        clr_ev(0, 5);
        step();
        expect_now(K_DONE, 0, 2, 1, "t1_done_cnt");
        expect_now(K_SUM,  0, 2, 37, "t1_lat_sum");
        expect_now(K_MAX,  0, 2, 37, "t1_lat_max");
        expect_now(K_PEND, 0, 5, 0, "t1_pending_cleared");
`ifdef VANILLA_SB_TRACKER_HIST_EN
        expect_now(K_HIST, 0, 2*LW + 5, 1, "t1_hist_bucket5");
`endif

        // RF1 r3 fdiv, then same-cycle clear + set idiv after 20 cycles.
        set_ev(1, 3, 1);
        step();
        idle(19);
        clr_ev(1, 3);
        set_ev(1, 3, 0);
        step();
        expect_now(K_DONE,  1, 1, 1, "t2_fdiv_done");
        expect_now(K_SUM,   1, 1, 20, "t2_fdiv_sum");
        expect_now(K_MAX,   1, 1, 20, "t2_fdiv_max");
        expect_now(K_PEND,  1, 3, 1, "t2_still_pending");
        expect_now(K_PCAT,  1, 3, 0, "t2_new_cat_idiv");
        expect_now(K_EDBL,  1, 0, 0, "t2_no_double");
        expect_now(K_EORPH, 1, 0, 0, "t2_no_orphan");
        idle(4);
        clr_ev(1, 3);
        step();
        expect_now(K_DONE, 1, 0, 1, "t2_idiv_done");
        expect_now(K_SUM,  1, 0, 5, "t2_idiv_restarted_timer");

        // RF0 r7 set twice; the clear counts once, timed from the second set. r8 set in the clearing cycle.
        set_ev(0, 7, 4);
        step();
        idle(3);
        set_ev(0, 7, 4);
        step();
        expect_now(K_EDBL,  0, 0, 1, "t3_double_set");
        expect_now(K_EORPH, 0, 0, 0, "t3_no_orphan");
        idle(9);
        clr_ev(0, 7);
        set_ev(0, 8, 3);
        step();
        expect_now(K_DONE, 0, 4, 1, "t3_single_retire");
        expect_now(K_SUM,  0, 4, 10, "t3_lat_from_second_set");
        expect_now(K_MAX,  0, 4, 10, "t3_lat_max");
        expect_now(K_EDBL, 0, 0, 1, "t3_double_sticky");
        expect_now(K_PEND, 0, 8, 1, "t3_other_reg_set");
        expect_now(K_PEND, 0, 7, 0, "t3_r7_cleared");

        // Shorter dram_load keeps the earlier max; minimum latency of 1 on group_load.
        set_ev(0, 6, 2);
        step();
        idle(3);
        clr_ev(0, 6);
        step();
        expect_now(K_DONE, 0, 2, 2, "t4_done_accum");
        expect_now(K_SUM,  0, 2, 41, "t4_sum_accum");
        expect_now(K_MAX,  0, 2, 37, "t4_max_kept");
        set_ev(0, 10, 5);
        step();
        clr_ev(0, 10);
        step();
        expect_now(K_SUM, 0, 5, 1, "t4_min_latency");
        expect_now(K_MAX, 0, 5, 1, "t4_min_latency_max");
`ifdef VANILLA_SB_TRACKER_HIST_EN
        expect_now(K_HIST, 0, 5*LW + 0, 1, "t4_hist_bucket0");
`endif

        // Orphan clear on idle RF0 r9.
        clr_ev(0, 9);
        step();
        expect_now(K_EORPH, 0, 0, 1, "t5_orphan");
        expect_now(K_EORPH, 1, 0, 0, "t5_rf1_unaffected");
        expect_now(K_DONE,  0, 2, 2, "t5_done_unchanged");
        expect_now(K_SUM,   0, 2, 41, "t5_sum_unchanged");

        // Timer saturation with lat_width_p = 4: held 40 cycles, reported as 15.
        s_if.set_v[0] = 1'b1; s_if.set_id[0 +: IDW] = 5'd2; s_if.set_cat[0 +: CATW] = 3'd0;
        step();
        idle(39);
        s_if.clear_v[0] = 1'b1; s_if.clear_id[0 +: IDW] = 5'd2;
        step();
        expect_now(K_S_DONE, 0, 0, 1, "t6_sat_done");
        expect_now(K_S_SUM,  0, 0, 15, "t6_sat_sum");
        expect_now(K_S_MAX,  0, 0, 15, "t6_sat_max");
`ifdef VANILLA_SB_TRACKER_HIST_EN
        expect_now(K_S_HIST, 0, 0*SLW + 3, 1, "t6_hist_bucket3");
`endif

        // Ten more pending entries, then a one-cycle reset that also beats a concurrent set.
        for (int i = 0; i < 10; i++) begin
            set_ev(0, 11 + i, i % 8);
            step();
        end
        expect_now(K_PWORD, 0, 0, 64'h1F_F900, "t7_pending_word");
        reset_n = 1'b0;
        set_ev(1, 1, 1);
        step();
        expect_now(K_ANY, 0, 0, 0, "t7_reset_clears_all");
        reset_n = 1'b1;
        clr_ev(0, 11);
        step();
        expect_now(K_EORPH, 0, 0, 1, "t7_orphan_after_reset");
        expect_now(K_EDBL,  0, 0, 0, "t7_double_cleared");
        expect_now(K_STAT,  0, 0, 0, "t7_stats_zero");
        expect_now(K_PWORD, 0, 0, 0, "t7_pending_zero");

        step();
        step();
        check(64'(q.size()), 64'd0, "all_expectations_consumed");
        if (errors == 0) $display("PASS CHECKS %0d ERRORS %0d", checks, errors);
        else             $display("FAIL CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
